// File: rtl/multicycle_mon_pkg.sv
// Shared types and helpers for the multicycle test monitor.
// Used by multicycle_test_monitor and mc_mon_channel.
package multicycle_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PASS    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_e;

    // Width of a counter that must be able to hold the value STABLE.
    function automatic int stab_cnt_w(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/mc_mon_channel.sv
// One monitored channel: latched expected value, stability counter, sticky hit.
// Optional hit-cycle stamp when MULTICYCLE_MON_STAMP_EN is defined.
module mc_mon_channel
    import multicycle_mon_pkg::*;
#(
    parameter int W      = 32,
    parameter int STABLE = 2,
    parameter int CW     = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          run,
    input  logic          en,
    input  logic [W-1:0]  test_val,
    input  logic [W-1:0]  exp_in,
`ifdef MULTICYCLE_MON_STAMP_EN
    input  logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] stamp,
`endif
    output logic          hit,
    output logic          hit_next
);

    localparam int            SW        = stab_cnt_w(STABLE);
    localparam logic [SW-1:0] STABLE_M1 = SW'(STABLE - 1);

    logic [W-1:0]  exp_q,  exp_d;
    logic [SW-1:0] stab_q, stab_d;
    logic          hit_q,  hit_d;

    always_comb begin
        exp_d  = exp_q;
        stab_d = stab_q;
        hit_d  = hit_q;
        if (start) begin
            exp_d  = exp_in;
            stab_d = '0;
            hit_d  = 1'b0;
        end else if (run && en && !hit_q) begin
            // Any mismatch discards accumulated stability; the STABLE-th match sets the hit.
            if (test_val == exp_q) begin
                stab_d = stab_q + 1'b1;
                if (stab_q == STABLE_M1) hit_d = 1'b1;
            end else begin
                stab_d = '0;
            end
        end
    end

    // NOTE: state flops take non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exp_q  <= '0;
            stab_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            exp_q  <= exp_d;
            stab_q <= stab_d;
            hit_q  <= hit_d;
        end
    end

`ifdef MULTICYCLE_MON_STAMP_EN
    logic [CW-1:0] stamp_q, stamp_d;

    always_comb begin
        stamp_d = stamp_q;
        if (start)             stamp_d = '0;
        else if (hit_d && !hit_q) stamp_d = cycle_cnt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) stamp_q <= '0;
        else     stamp_q <= stamp_d;
    end

    assign stamp = stamp_q;
`endif

    assign hit      = hit_q;
    assign hit_next = hit_d;

endmodule

// File: rtl/multicycle_test_monitor.sv
// Self-check monitor: waits for every enabled channel to hold its expected value, or times out.
// Define MULTICYCLE_MON_STAMP_EN to add the per-channel hit_stamp output.
module multicycle_test_monitor
    import multicycle_mon_pkg::*;
#(
    parameter int W       = 32,
    parameter int NCH     = 4,
    parameter int STABLE  = 2,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*W-1:0]  test_val,
    input  logic [NCH*W-1:0]  exp_val,
`ifdef MULTICYCLE_MON_STAMP_EN
    output logic [NCH*CW-1:0] hit_stamp,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [NCH-1:0]    ch_hit,
    output logic [CW-1:0]     cycle_cnt
);

    localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT - 1);

    mon_state_e     state_q, state_d;
    logic [NCH-1:0] mask_q,  mask_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [NCH-1:0] hit_next;
    logic           run;
    logic           all_hit_next;

    assign run = (state_q == ST_RUN);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mc_mon_channel #(
            .W      (W),
            .STABLE (STABLE),
            .CW     (CW)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .start    (start),
            .run      (run),
            .en       (mask_q[i]),
            .test_val (test_val[i*W +: W]),
            .exp_in   (exp_val[i*W +: W]),
`ifdef MULTICYCLE_MON_STAMP_EN
            .cycle_cnt(cnt_q),
            .stamp    (hit_stamp[i*CW +: CW]),
`endif
            .hit      (ch_hit[i]),
            .hit_next (hit_next[i])
        );
    end

    // Uses next-cycle hits so a final hit on the last budget cycle still wins over timeout.
    assign all_hit_next = &(hit_next | ~mask_q);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        timed_out = 1'b0;

        if (start) begin
            state_d = ST_RUN;
            mask_d  = ch_en;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (all_hit_next)              state_d = ST_PASS;
            else if (cnt_q == LAST_CYCLE)  state_d = ST_TIMEOUT;
            else if (cnt_q != '1)          cnt_d   = cnt_q + 1'b1;
        end

        case (state_q)
            ST_RUN:     busy = 1'b1;
            ST_PASS:    begin done = 1'b1; pass      = 1'b1; end
            ST_TIMEOUT: begin done = 1'b1; timed_out = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_test_monitor.sv
// Directed self-checking bench for multicycle_test_monitor (default parameters).
module tb_multicycle_test_monitor;

    localparam int W       = 32;
    localparam int NCH     = 4;
    localparam int STABLE  = 2;
    localparam int CW      = 16;
    localparam int TIMEOUT = 1000;

    logic              CLK;
    logic              RST;
    logic              start;
    logic [NCH-1:0]    ch_en;
    logic [NCH*W-1:0]  test_val;
    logic [NCH*W-1:0]  exp_val;
    logic              busy, done, pass, timed_out;
    logic [NCH-1:0]    ch_hit;
    logic [CW-1:0]     cycle_cnt;
`ifdef MULTICYCLE_MON_STAMP_EN
    logic [NCH*CW-1:0] hit_stamp;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_test_monitor #(
        .W(W), .NCH(NCH), .STABLE(STABLE), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .ch_en    (ch_en),
        .test_val (test_val),
        .exp_val  (exp_val),
`ifdef MULTICYCLE_MON_STAMP_EN
        .hit_stamp(hit_stamp),
`endif
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .timed_out(timed_out),
        .ch_hit   (ch_hit),
        .cycle_cnt(cycle_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_tv(input int i, input logic [W-1:0] v);
        test_val[i*W +: W] = v;
    endtask

    task automatic set_exp(input int i, input logic [W-1:0] v);
        exp_val[i*W +: W] = v;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; ch_en = '0; test_val = '0; exp_val = '0;
        #12;
        checks++; if ({busy, done, pass, timed_out} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, timed_out}); end
        checks++; if (ch_hit !== 4'b0000 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL reset_vals: hit %b cnt %0d want 0000/0", ch_hit, cycle_cnt); end
        @(posedge CLK); #1; RST = 1'b0;
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_idle: busy/done %b want 00", {busy, done}); end
    endtask

    task automatic test_single_hit();
        ch_en = 4'b0001; set_exp(0, 32'd69); test_val = '0;
        do_start();
        repeat (3) tick();
        set_tv(0, 32'd69);
        tick();
        checks++; if (ch_hit !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL t1_cycle4: hit %b busy %b want 0000/1", ch_hit, busy); end
        tick();
        checks++; if (ch_hit !== 4'b0001) begin errors++; $display("FAIL t1_hit: got %b want 0001", ch_hit); end
        checks++; if ({busy, done, pass, timed_out} !== 4'b0110) begin errors++; $display("FAIL t1_flags: got %b want 0110", {busy, done, pass, timed_out}); end
        checks++; if (cycle_cnt !== 16'd4) begin errors++; $display("FAIL t1_cnt: got %0d want 4", cycle_cnt); end
    endtask

    task automatic test_timeout();
        ch_en = 4'b0001; set_exp(0, 32'd69); test_val = '0;
        do_start();
        for (int k = 0; k < TIMEOUT; k++) begin
            set_tv(0, (k % 2 == 0) ? 32'd69 : 32'd0);
            if (k == TIMEOUT - 1) begin
                checks++; if (busy !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL t2_last_run: busy %b to %b want 1/0", busy, timed_out); end
            end
            tick();
        end
        checks++; if ({busy, done, pass, timed_out} !== 4'b0101) begin errors++; $display("FAIL t2_flags: got %b want 0101", {busy, done, pass, timed_out}); end
        checks++; if (cycle_cnt !== 16'd999 || ch_hit !== 4'b0000) begin errors++; $display("FAIL t2_cnt: cnt %0d hit %b want 999/0000", cycle_cnt, ch_hit); end
        repeat (3) tick();
        checks++; if (cycle_cnt !== 16'd999 || timed_out !== 1'b1) begin errors++; $display("FAIL t2_frozen: cnt %0d to %b want 999/1", cycle_cnt, timed_out); end
    endtask

    task automatic test_masked_channels();
        ch_en = 4'b0101;
        set_exp(0, 32'hA5A5_0001); set_exp(1, 32'h0000_1111);
        set_exp(2, 32'hDEAD_BEEF); set_exp(3, 32'h0000_3333);
        test_val = '0; set_tv(1, 32'h0000_1111); set_tv(3, 32'h0000_3333);
        do_start();
        ch_en = 4'b1111; exp_val = '0;
        for (int k = 0; k < 22; k++) begin
            if (k == 10) set_tv(0, 32'hA5A5_0001);
            if (k == 20) set_tv(2, 32'hDEAD_BEEF);
            if (k == 12) begin
                checks++; if (ch_hit !== 4'b0001) begin errors++; $display("FAIL t3_ch0: got %b want 0001", ch_hit); end
            end
            if (k == 21) begin
                checks++; if (ch_hit !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL t3_c21: hit %b busy %b want 0001/1", ch_hit, busy); end
            end
            tick();
        end
        checks++; if (pass !== 1'b1 || ch_hit !== 4'b0101) begin errors++; $display("FAIL t3_pass: pass %b hit %b want 1/0101", pass, ch_hit); end
        checks++; if (cycle_cnt !== 16'd21) begin errors++; $display("FAIL t3_cnt: got %0d want 21", cycle_cnt); end
        set_tv(0, 32'h0);
        tick();
        checks++; if (ch_hit !== 4'b0101) begin errors++; $display("FAIL t3_sticky: got %b want 0101", ch_hit); end
    endtask

    task automatic test_hit_on_last_cycle();
        ch_en = 4'b0001; set_exp(0, 32'd77); test_val = '0;
        do_start();
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k == TIMEOUT - 2) set_tv(0, 32'd77);
            if (k == TIMEOUT - 1) begin
                checks++; if (ch_hit !== 4'b0000) begin errors++; $display("FAIL t4_prehit: got %b want 0000", ch_hit); end
            end
            tick();
        end
        checks++; if (pass !== 1'b1 || timed_out !== 1'b0) begin errors++; $display("FAIL t4_pass_wins: pass %b to %b want 1/0", pass, timed_out); end
        checks++; if (cycle_cnt !== 16'd999 || ch_hit !== 4'b0001) begin errors++; $display("FAIL t4_vals: cnt %0d hit %b want 999/0001", cycle_cnt, ch_hit); end
    endtask

    task automatic test_empty_mask();
        ch_en = 4'b0000; test_val = '0; exp_val = '1;
        do_start();
        checks++; if (busy !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL t_mask0_run: busy %b pass %b want 1/0", busy, pass); end
        tick();
        checks++; if (pass !== 1'b1 || ch_hit !== 4'b0000 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL t_mask0_pass: pass %b hit %b cnt %0d want 1/0000/0", pass, ch_hit, cycle_cnt); end
    endtask

    task automatic test_restart_and_reset();
        ch_en = 4'b0001; set_exp(0, 32'd55); test_val = '0;
        do_start();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t5_from_pass: busy %b done %b want 1/0", busy, done); end
        for (int k = 0; k < 50; k++) begin
            if (k == 49) set_tv(0, 32'd55);
            tick();
        end
        do_start();
        checks++; if (cycle_cnt !== 16'd0 || ch_hit !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL t5_restart: cnt %0d hit %b busy %b want 0/0000/1", cycle_cnt, ch_hit, busy); end
        tick();
        checks++; if (ch_hit !== 4'b0000) begin errors++; $display("FAIL t5_partial: got %b want 0000", ch_hit); end
        tick();
        checks++; if (ch_hit !== 4'b0001 || pass !== 1'b1) begin errors++; $display("FAIL t5_rehit: hit %b pass %b want 0001/1", ch_hit, pass); end

        test_val = '0;
        do_start();
        repeat (5) tick();
        set_tv(0, 32'd55);
        tick();
        #2 RST = 1'b1;
        #1;
        checks++; if ({busy, done, pass, timed_out, ch_hit} !== 8'h00 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL t5_async_rst: flags/hit %h cnt %0d want 00/0", {busy, done, pass, timed_out, ch_hit}, cycle_cnt); end
        @(posedge CLK); #1; RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({busy, done, pass, timed_out, ch_hit} !== 8'h00 || cycle_cnt !== 16'd0) begin errors++; $display("FAIL t5_post_rst%0d: flags/hit %h cnt %0d want 00/0", k, {busy, done, pass, timed_out, ch_hit}, cycle_cnt); end
            tick();
        end
    endtask

`ifdef MULTICYCLE_MON_STAMP_EN
    task automatic test_stamp();
        ch_en = 4'b0011; set_exp(0, 32'd7); set_exp(1, 32'd12); test_val = '0;
        do_start();
        for (int k = 0; k < 14; k++) begin
            if (k == 6)  set_tv(0, 32'd7);
            if (k == 11) set_tv(1, 32'd12);
            tick();
        end
        checks++; if (hit_stamp[CW-1:0] !== 16'd7 || hit_stamp[2*CW-1:CW] !== 16'd12) begin errors++; $display("FAIL t6_stamp: got %0d,%0d want 7,12", hit_stamp[CW-1:0], hit_stamp[2*CW-1:CW]); end
        checks++; if (pass !== 1'b1 || ch_hit !== 4'b0011) begin errors++; $display("FAIL t6_pass: pass %b hit %b want 1/0011", pass, ch_hit); end
        test_val = '0;
        do_start();
        checks++; if (hit_stamp !== '0) begin errors++; $display("FAIL t6_clear: got %h want 0", hit_stamp); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_hit();
        test_timeout();
        test_masked_channels();
        test_hit_on_last_cycle();
        test_empty_mask();
        test_restart_and_reset();
`ifdef MULTICYCLE_MON_STAMP_EN
        test_stamp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
